// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared definitions for the bit-serial subtractor: FSM state
//                encoding and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_subtractor_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor_bit
//  Description : Combinational 1-bit full subtractor, d = a - b - bin.
//  Ports       : a, b, bin  - operand bits and borrow-in
//                d          - difference bit
//                bout       - borrow-out (1 when a < b + bin)
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor, oData = iData_a - iData_b - iB,
//                one bit per clock LSB first, with start/busy/done handshake.
//  Ports       : iClk, iReset      - clock, synchronous active-high reset
//                iStart            - request, only honoured while idle
//                iData_a, iData_b  - minuend / subtrahend, latched on accept
//                iB                - borrow-in, latched on accept
//                oData, oData_B    - last completed difference and borrow-out
//                oBusy             - operation in progress (SHIFT or DONE)
//                oDone             - one-cycle pulse when results update
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic             iB,
    output logic [WIDTH-1:0] oData,
    output logic             oData_B,
    output logic             oBusy,
    output logic             oDone
);

    localparam int             CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Holds the WIDTH-1 most recent difference bits; the final bit is
    // concatenated on the completing edge instead of being stored.
    logic [WIDTH-2:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;

    logic               w_accept;
    logic               w_lastBit;
    logic               w_diffBit;
    logic               w_borrowOut;
    logic [WIDTH-1:0]   w_resNext;

    full_subtractor_bit u_fsBit (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_diffBit),
        .bout (w_borrowOut)
    );

    // Shifting right with the new bit at the MSB leaves, after the last
    // bit, the full LSB-first difference aligned in w_resNext.
    assign w_resNext = {w_diffBit, r_res};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_lastBit   = 1'b0;
        oBusy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_accept    = 1'b1;
                    w_stateNext = S_SHIFT;
                end
            end
            S_SHIFT: begin
                oBusy = 1'b1;
                if (r_count == c_lastCount) begin
                    w_lastBit   = 1'b1;
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                oBusy       = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, borrow, counter and result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_done   <= 1'b0;
            oData    <= '0;
            oData_B  <= 1'b0;
        end else begin
            // Pulses only on the completing edge; cleared by the DONE edge.
            r_done <= w_lastBit;
            if (w_accept) begin
                r_a      <= iData_a;
                r_b      <= iData_b;
                r_borrow <= iB;
                r_count  <= '0;
            end else if (r_state == S_SHIFT) begin
                r_a      <= r_a >> 1;
                r_b      <= r_b >> 1;
                r_res    <= w_resNext[WIDTH-1:1];
                r_borrow <= w_borrowOut;
                r_count  <= r_count + CNT_W'(1);
                if (w_lastBit) begin
                    oData   <= w_resNext;
                    oData_B <= w_borrowOut;
                end
            end
        end
    end

    assign oDone = r_done;

endmodule : serial_subtractor
`default_nettype wire
